serial_bus_master: RTL and testbench
====================================

# serial_bus_master

Serial-command bus initiator that lets a host load and inspect memory over the UART link without CPU involvement. It consumes received bytes from the UART's byte-level receive interface, parses fixed-format read/write commands, drives the 30-bit word-addressed memory bus as initiator, and returns replies through the UART's byte-level transmit interface. It sits beside `yarvi` on the board bus; the top level muxes bus ownership (outside this block).

## Interface
- `TIMEOUT_CYCLES`, 5_000_000: idle cycles between command bytes before the parser aborts to IDLE (100 ms at 50 MHz).
- `READ_LATENCY`, 1: cycles from `readenable` to valid `readdata`; range 1..3.

- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_q`  in  8  received byte, valid when `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `tx_data`  out  8  byte to transmit, valid with `tx_valid`.
- `tx_valid`  out  1  one-cycle strobe requesting transmission of `tx_data`.
- `tx_busy`  in  1  UART transmitter busy; may lag `tx_valid` by one cycle.
- `address`  out  30  bus word address (byte address bits 31:2).
- `writeenable`  out  1  one-cycle write strobe.
- `writedata`  out  32  write data.
- `byteena`  out  4  byte enables; always 4'hF.
- `readenable`  out  1  one-cycle read strobe.
- `readdata`  in  32  read data, sampled `READ_LATENCY` cycles after `readenable`.
- `busy`  out  1  high whenever state ≠ IDLE (top level uses it to grant bus).

## Operation
- Command formats, all multi-byte fields MSB first:
  - Write: 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0 → one bus write, reply 0x4B 'K'.
  - Read: 0x52 'R', A3 A2 A1 A0 → one bus read, reply D3 D2 D1 D0.
  - Any other first byte → reply 0x3F '?', return to IDLE.
- `address` = {A3..A0}[31:2]; byte-address bits 1:0 are discarded (no alignment error).
- States: IDLE → ADDR (4 bytes) → DATA (W only, 4 bytes) → BUS_WR or BUS_RD → RD_WAIT (R only) → TX → TX_GAP → TX (next byte) or IDLE.
- 2-bit byte counter shared by ADDR, DATA, TX; wraps 3→0 on state exit.
- Inter-byte timeout: counter cleared on each accepted `rx_valid` in ADDR/DATA; reaching `TIMEOUT_CYCLES` → IDLE, partial command discarded, no reply.
- `rx_valid` outside IDLE/ADDR/DATA (bus phase, TX, TX_GAP) is dropped; the host must wait for the reply.
- `readdata` captured into the reply shift register exactly `READ_LATENCY` cycles after `readenable`.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `writeenable`=0, `readenable`=0, `address`=0, `writedata`=0, `byteena`=4'hF, `busy`=0, state IDLE, counters 0.
- All outputs registered.
- BUS_WR: `writeenable` high one cycle, entered the cycle after the 9th byte's `rx_valid`; `address`/`writedata` stable from that cycle until the next command.
- BUS_RD: `readenable` high one cycle, cycle after the 5th byte's `rx_valid`.
- TX: `tx_valid` pulsed only in a cycle where `tx_busy`=0; TX_GAP always lasts ≥1 cycle after a pulse, then waits for `tx_busy`=0 before the next byte. No back-to-back `tx_valid`.
- `busy` deasserts the cycle after the last reply byte's `tx_valid`.
- Reset mid-command or mid-reply: immediate return to IDLE; any unsent reply bytes are lost; no bus strobe is issued.

## Structure
- Shared package `serial_bus_pkg`: state enum, command constants (CMD_READ 8'h52, CMD_WRITE 8'h57, RSP_OK 8'h4B, RSP_ERR 8'h3F).
- Single module, no sub-modules; timeout counter is inline.

## Test plan
- Write: send 57 00 00 01 00 DE AD BE EF → one `writeenable` pulse, `address`=30'h40, `writedata`=32'hDEADBEEF, `byteena`=F; reply 4B.
- Read: send 52 00 00 01 00, bench returns 32'h12345678 at latency 1 → `readenable` once at `address`=30'h40; replies 12 34 56 78 in order, no overlap with `tx_busy`.
- Unknown/misaligned: send 41 → reply 3F; send 52 00 00 01 03 → `address`=30'h40.
- Timeout: send 57 00 00, stall `TIMEOUT_CYCLES` (reduced to 100 in bench) → no bus strobe, no reply, `busy`=0; following 52 … command executes normally.
- Lagging `tx_busy`: UART model raises `tx_busy` one cycle after `tx_valid`, holds 20 cycles → exactly 4 `tx_valid` pulses for a read, each after `tx_busy` falls.
- Reset during TX after 2 of 4 read-reply bytes → outputs at reset values; no further `tx_valid`; next command works.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared types and byte codes for the UART-driven serial bus initiator.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_WAIT,
        ST_TX,
        ST_TX_GAP
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

endpackage

// File: rtl/serial_bus_master.sv
// Parses 'W'/'R' commands from UART bytes, runs one 32-bit bus access, and replies over UART.
// Bus strobe one cycle after the last command byte; reply bytes are paced by tx_busy with a guaranteed gap.
module serial_bus_master
    import serial_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int READ_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_q,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_busy,
    output logic [29:0] address,
    output logic        writeenable,
    output logic [31:0] writedata,
    output logic [3:0]  byteena,
    output logic        readenable,
    input  logic [31:0] readdata,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    state_t        state_next;
    logic [1:0]    byte_cnt;
    logic [1:0]    lat_cnt;
    logic [TW-1:0] idle_cnt;
    logic [31:0]   sr;
    logic [31:0]   sr_in;
    logic          is_read;
    logic          tx_last;
    logic          gap_done;
    logic          timed_out;
    logic          lat_done;

    assign sr_in     = {sr[23:0], rx_q};
    assign timed_out = (idle_cnt == TW'(TIMEOUT_CYCLES));
    assign lat_done  = (lat_cnt == 2'(READ_LATENCY - 1));
    assign byteena   = 4'hF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    state_next = (rx_q == CMD_READ || rx_q == CMD_WRITE) ? ST_ADDR : ST_TX;
                end
            end
            ST_ADDR: begin
                if (rx_valid && byte_cnt == 2'd3) begin
                    state_next = is_read ? ST_BUS_RD : ST_DATA;
                end else if (!rx_valid && timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_valid && byte_cnt == 2'd3) begin
                    state_next = ST_BUS_WR;
                end else if (!rx_valid && timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUS_WR:  state_next = ST_TX;
            ST_BUS_RD:  state_next = ST_RD_WAIT;
            ST_RD_WAIT: if (lat_done) state_next = ST_TX;
            ST_TX:      if (!tx_busy) state_next = ST_TX_GAP;
            ST_TX_GAP: begin
                // gap_done holds off one extra cycle so a lagging tx_busy is seen before the next byte
                if (tx_last) begin
                    state_next = ST_IDLE;
                end else if (gap_done && !tx_busy) begin
                    state_next = ST_TX;
                end
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            writeenable <= 1'b0;
            readenable  <= 1'b0;
            address     <= 30'h0;
            writedata   <= 32'h0;
            busy        <= 1'b0;
            byte_cnt    <= 2'd0;
            lat_cnt     <= 2'd0;
            idle_cnt    <= '0;
            sr          <= 32'h0;
            is_read     <= 1'b0;
            tx_last     <= 1'b0;
            gap_done    <= 1'b0;
        end else begin
            writeenable <= (state_next == ST_BUS_WR);
            readenable  <= (state_next == ST_BUS_RD);
            busy        <= (state_next != ST_IDLE);
            tx_valid    <= 1'b0;
            idle_cnt    <= '0;
            lat_cnt     <= 2'd0;
            case (state)
                ST_IDLE: begin
                    byte_cnt <= 2'd0;
                    if (rx_valid) begin
                        is_read <= (rx_q == CMD_READ);
                        sr      <= {RSP_ERR, 24'h0};
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (rx_valid) begin
                        sr       <= sr_in;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (state == ST_ADDR) address   <= sr_in[31:2];
                            else                  writedata <= sr_in;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                ST_BUS_WR: sr <= {RSP_OK, 24'h0};
                ST_RD_WAIT: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_done) sr <= readdata;
                end
                ST_TX: begin
                    if (!tx_busy) begin
                        tx_valid <= 1'b1;
                        tx_data  <= sr[31:24];
                        sr       <= {sr[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        tx_last  <= !is_read || byte_cnt == 2'd3;
                        gap_done <= 1'b0;
                    end
                end
                ST_TX_GAP: gap_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_master.sv
// Directed-vector bench with a scoreboard monitor for the serial bus initiator.
module tb_serial_bus_master;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_q;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic [29:0] address;
    logic        writeenable;
    logic [31:0] writedata;
    logic [3:0]  byteena;
    logic        readenable;
    logic [31:0] readdata;
    logic        busy;

    typedef struct {
        bit          is_wr;
        logic [29:0] addr;
        logic [31:0] data;
    } bus_t;

    logic [7:0]  exp_tx[$];
    bus_t        exp_bus[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          tx_pulses = 0;
    int          bus_strobes = 0;
    int          busy_cnt = 0;
    bit          lag_mode = 0;
    bit          lag_pend = 0;
    bit          prev_txv = 0;
    logic [31:0] rd_value = 32'h0;

    always #10 clk = ~clk;

    serial_bus_master #(.TIMEOUT_CYCLES(TMO), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .rx_q(rx_q), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .address(address), .writeenable(writeenable), .writedata(writedata),
        .byteena(byteena), .readenable(readenable), .readdata(readdata), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory model: data only valid exactly one cycle after readenable.
    always @(posedge clk) readdata <= readenable ? rd_value : 32'hBAD0BAD0;

    // UART model: busy for 20 cycles after a byte, optionally starting one cycle late.
    always @(posedge clk) begin
        if (tx_valid) begin
            if (lag_mode) lag_pend <= 1'b1;
            else          busy_cnt <= 20;
        end else if (lag_pend) begin
            lag_pend <= 1'b0;
            busy_cnt <= 20;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid) begin
                tx_pulses++;
                chk("tx_while_busy", tx_busy, 0);
                chk("tx_back_to_back", prev_txv, 0);
                if (exp_tx.size() == 0) chk("tx_unexpected", tx_data, 64'hFFFF_FFFF);
                else chk("tx_byte", tx_data, exp_tx.pop_front());
            end
            if (writeenable || readenable) begin
                bus_t e;
                bus_strobes++;
                if (exp_bus.size() == 0) begin
                    chk("bus_unexpected", {writeenable, readenable}, 0);
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus_kind", {writeenable, readenable}, e.is_wr ? 2'b10 : 2'b01);
                    chk("bus_addr", address, e.addr);
                    chk("bus_byteena", byteena, 4'hF);
                    if (e.is_wr) chk("bus_wdata", writedata, e.data);
                end
            end
        end
        prev_txv = tx_valid && !reset;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_q = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, exp_tx.size() + exp_bus.size(), 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [29:0] exp_a);
        rd_value = d;
        exp_bus.push_back('{is_wr: 0, addr: exp_a, data: 32'h0});
        exp_tx.push_back(d[31:24]);
        exp_tx.push_back(d[23:16]);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
        send_byte(8'h52);
        send_byte(a[31:24]);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_writeenable"}, writeenable, 0);
        chk({tag, "_readenable"}, readenable, 0);
        chk({tag, "_address"}, address, 0);
        chk({tag, "_writedata"}, writedata, 0);
        chk({tag, "_byteena"}, byteena, 4'hF);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int p0;
        int b0;
        int n;
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_q = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Write 0xDEADBEEF to byte address 0x100
        p0 = tx_pulses;
        exp_bus.push_back('{is_wr: 1, addr: 30'h40, data: 32'hDEADBEEF});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_idle("write");
        chk("write_pulses", tx_pulses - p0, 1);
        chk("write_addr_hold", address, 30'h40);
        chk("write_data_hold", writedata, 32'hDEADBEEF);

        // Read
        p0 = tx_pulses;
        do_read(32'h0000_0100, 32'h12345678, 30'h40);
        wait_idle("read");
        chk("read_pulses", tx_pulses - p0, 4);

        // Unknown command
        exp_tx.push_back(8'h3F);
        send_byte(8'h41);
        wait_idle("unknown");

        // Misaligned address drops low bits
        do_read(32'h0000_0103, 32'hCAFEF00D, 30'h40);
        wait_idle("misaligned");

        // Partial command then stall past the timeout
        p0 = tx_pulses;
        b0 = bus_strobes;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        repeat (TMO + 50) @(posedge clk);
        @(negedge clk);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_tx", tx_pulses - p0, 0);
        chk("timeout_no_bus", bus_strobes - b0, 0);
        do_read(32'h0000_0010, 32'h0A0B0C0D, 30'h4);
        wait_idle("after_timeout");

        // Lagging tx_busy
        lag_mode = 1'b1;
        p0 = tx_pulses;
        do_read(32'h0000_0200, 32'h87654321, 30'h80);
        wait_idle("lag");
        chk("lag_pulses", tx_pulses - p0, 4);
        lag_mode = 1'b0;

        // Reset after 2 of 4 reply bytes
        p0 = tx_pulses;
        do_read(32'h0000_0300, 32'hA1B2C3D4, 30'hC0);
        n = 0;
        while (tx_pulses - p0 < 2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("midreply_two_sent", tx_pulses - p0, 2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreply");
        exp_tx.delete();
        exp_bus.delete();
        @(negedge clk);
        reset = 1'b0;
        p0 = tx_pulses;
        repeat (80) @(negedge clk);
        chk("midreply_no_more_tx", tx_pulses - p0, 0);
        exp_bus.push_back('{is_wr: 1, addr: 30'h2, data: 32'h01020304});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_idle("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
